fifo_rd_stage: RTL
==================

Name: fifo_rd_stage

Overview:
- Read-side consumer stage that sits directly downstream of the FIFO.
- Pulls words out of the FIFO through its rd_en/empty/data_out interface, absorbing the FIFO's one-cycle read latency.
- Re-presents the words on a valid/ready stream with a 2-entry skid buffer, so the sink may stall freely without losing data and sustains one word per cycle when unstalled.
- Also keeps a beat counter and a sticky underflow error flag for the monitor and scoreboard to check.

Parameters:
- FIFO_WIDTH, 16, data width; must match the FIFO.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_underflow  input  1  FIFO underflow flag.
- fifo_rd_en  output  1  read request to the FIFO.
- m_valid  output  1  output word valid.
- m_data  output  FIFO_WIDTH  output word.
- m_ready  input  1  sink ready.
- beat_count  output  CNT_W  number of words delivered (m_valid & m_ready).
- underflow_err  output  1  sticky: FIFO reported underflow.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state clear immediately:
  - fifo_rd_en=0, m_valid=0, m_data=0, beat_count=0, underflow_err=0.
  - Buffer occupancy=0, inflight=0.
- Reset mid-operation discards any buffered word and any in-flight word already popped from the FIFO; no recovery is attempted.
- State:
  - occ: 0..2, entries held in the skid buffer.
  - inflight: 1 bit, a read was issued on the previous edge.
  - Buffer is two FIFO_WIDTH registers; m_data always drives the oldest entry.
- Read issue, combinational:
  - pop = m_valid & m_ready.
  - fifo_rd_en = !fifo_empty & ((occ + inflight - pop) < 2).
  - fifo_rd_en is never asserted while fifo_empty=1. It depends combinationally on m_ready; the sink must not derive m_ready from fifo_rd_en.
- Latency:
  - fifo_rd_en high in cycle N → inflight=1 in cycle N+1.
  - fifo_data_out is captured at the end of N+1, so m_valid goes high in cycle N+2.
  - Minimum latency from rd_en to output is 2 cycles.
- Capture:
  - When inflight=1, fifo_data_out is written into the buffer at the next edge, behind any existing entry.
  - Capture and pop in the same cycle:
    - occ unchanged.
    - If occ was 1, the captured word becomes the output word.
    - If occ was 2, the second entry shifts to the output and the captured word fills slot 2.
- Occupancy update: occ_next = occ + inflight - pop. It never exceeds 2, which is guaranteed by the issue rule.
- m_valid = (occ != 0). Once m_valid is high with m_ready low, m_valid and m_data hold stable until accepted.
- Throughput: with m_ready held high and the FIFO non-empty, one word per cycle after the initial 2-cycle fill.
- Stall: with m_ready low, at most 2 words are pulled from the FIFO, then fifo_rd_en stays low until a pop occurs.
- beat_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- underflow_err is set on any edge where fifo_underflow=1 and is cleared only by reset. This block never causes underflow, so a set flag indicates an external protocol violation.
- Ordering: words leave in exactly the order they were read from the FIFO; no duplication or drop except on reset.

Test Plan:
- Reset then idle: fifo_empty=1 → fifo_rd_en=0, m_valid=0, beat_count=0 for 20 cycles.
- Streaming: FIFO holds 0x0001..0x0008, m_ready=1 → fifo_rd_en first high in cycle 0. m_valid high from cycle 2 with data 0x0001..0x0008 on consecutive cycles. beat_count=8, then m_valid=0.
- Back-pressure: FIFO holds 5 words, m_ready=0 → exactly 2 rd_en pulses and occ=2, with m_data=first word held stable. Raising m_ready delivers all 5 in order, with no gap after the first.
- Simultaneous capture and pop at occ=2: toggle m_ready 1/0 every cycle with a full FIFO → output sequence is in order with no loss, and fifo_rd_en is never high when occ+inflight-pop would reach 3.
- Empty boundary: FIFO holds 1 word and goes empty → exactly one rd_en pulse, fifo_rd_en=0 while fifo_empty=1. An externally forced fifo_underflow=1 sets underflow_err=1, which stays set until rst_n low.
- Reset mid-stream: assert rst_n low while occ=2 and inflight=1 → m_valid=0 and beat_count=0 immediately (asynchronous). After release, the next delivered word is the next FIFO word, not a buffered one.

Source files
------------

// File: rtl/fifo_rd_stage.sv
// Read-side consumer stage behind the FIFO: absorbs the one-cycle read latency
// and re-presents words on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stage #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      beat_count,
    output logic                  underflow_err
);

    logic [1:0]            occ_r;
    logic [1:0]            occ_next_s;
    logic                  inflight_r;
    logic                  run_r;
    logic                  m_valid_r;
    logic                  pop_s;
    logic                  rd_en_s;
    logic [2:0]            level_s;
    logic [FIFO_WIDTH-1:0] buf0_r;
    logic [FIFO_WIDTH-1:0] buf1_r;
    logic [FIFO_WIDTH-1:0] buf0_next_s;
    logic [FIFO_WIDTH-1:0] buf1_next_s;
    logic [CNT_W-1:0]      beat_r;
    logic                  underflow_r;

    assign pop_s   = m_valid_r & m_ready;
    assign level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    // run_r keeps reads off while reset is held and for the first edge after release
    assign rd_en_s = run_r & ~fifo_empty & (level_s < 3'd2);

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = m_valid_r;
    assign m_data        = buf0_r;
    assign beat_count    = beat_r;
    assign underflow_err = underflow_r;

    // Skid-buffer next state: capture lands behind the oldest entry, pop shifts forward
    always_comb begin
        buf0_next_s = buf0_r;
        buf1_next_s = buf1_r;
        occ_next_s  = level_s[1:0];
        case ({inflight_r, pop_s})
            2'b01: begin
                buf0_next_s = buf1_r;
            end
            2'b10: begin
                if (occ_r == 2'd0) begin
                    buf0_next_s = fifo_data_out;
                end else begin
                    buf1_next_s = fifo_data_out;
                end
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    buf0_next_s = fifo_data_out;
                end else begin
                    buf0_next_s = buf1_r;
                    buf1_next_s = fifo_data_out;
                end
            end
            default: begin
                buf0_next_s = buf0_r;
                buf1_next_s = buf1_r;
            end
        endcase
    end

    // Buffer, occupancy and read-tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            run_r      <= 1'b0;
            m_valid_r  <= 1'b0;
            buf0_r     <= {FIFO_WIDTH{1'b0}};
            buf1_r     <= {FIFO_WIDTH{1'b0}};
        end else begin
            occ_r      <= occ_next_s;
            inflight_r <= rd_en_s;
            run_r      <= 1'b1;
            m_valid_r  <= (occ_next_s != 2'd0);
            buf0_r     <= buf0_next_s;
            buf1_r     <= buf1_next_s;
        end
    end

    // Delivered-beat counter (wraps) and sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_r      <= {CNT_W{1'b0}};
            underflow_r <= 1'b0;
        end else begin
            if (pop_s) begin
                beat_r <= beat_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                beat_r <= beat_r;
            end
            if (fifo_underflow) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

endmodule
